// File: rtl/andtree_chk_pkg.sv
// Shared constants, FSM state encodings and the Gray-code helper for the AND-tree sweep checker.
package andtree_chk_pkg;

  localparam int N_IN_DEF    = 4;
  localparam int SETTLE_DEF  = 4;
  localparam int TIMEOUT_DEF = 32;
  localparam int ERR_W_DEF   = 8;
  localparam int LAT_W_DEF   = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CHECK   = 2'd1;
  localparam state_t ST_ADVANCE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  function automatic logic [31:0] gray(input logic [31:0] k);
    return k ^ (k >> 1);
  endfunction

endpackage

// File: rtl/andtree_sync2.sv
// Two-flop synchronizer for the asynchronous AND-tree output; clears to 0 on reset.
module andtree_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/and_tree_sweep_checker.sv
// Gray-code sweep of the AND-tree leaves with settle/timeout checking and worst-latency capture.
// Optional macro ANDTREE_CHK_FIRST_FAIL_EN adds first_fail_idx/first_fail_vld outputs.
module and_tree_sweep_checker
  import andtree_chk_pkg::*;
#(
  parameter int N_IN           = N_IN_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int ERR_W          = ERR_W_DEF,
  parameter int LAT_W          = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z_in,
  output logic [N_IN-1:0]  drv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN-1:0]  vec_index,
  output logic [ERR_W-1:0] err_count,
  output logic [LAT_W-1:0] max_latency
`ifdef ANDTREE_CHK_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]  first_fail_idx,
  output logic             first_fail_vld
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [31:0] LAT_MAX = (LAT_W >= 32) ? 32'hffff_ffff : ((32'd1 << LAT_W) - 32'd1);

  logic          z_s;
  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] streak;
  logic          match;
  logic          accept;
  logic          timeout;
  logic [31:0]   lat_raw;
  logic [LAT_W-1:0] lat_new;

  andtree_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (z_in),
    .q     (z_s)
  );

  assign match   = (z_s == (&drv));
  assign accept  = (state == ST_CHECK) && match && (streak == SW'(SETTLE_CYCLES - 1));
  assign timeout = (state == ST_CHECK) && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Accepting cycle is the last of the streak, so the streak began SETTLE_CYCLES-1 cycles earlier.
  assign lat_raw = 32'(timer) - 32'(SETTLE_CYCLES - 1);
  assign lat_new = LAT_W'((lat_raw > LAT_MAX) ? LAT_MAX : lat_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      drv            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_index      <= '0;
      err_count      <= '0;
      max_latency    <= '0;
      timer          <= '0;
      streak         <= '0;
`ifdef ANDTREE_CHK_FIRST_FAIL_EN
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_index      <= '0;
            drv            <= '0;
            err_count      <= '0;
            max_latency    <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            timer          <= '0;
            streak         <= '0;
`ifdef ANDTREE_CHK_FIRST_FAIL_EN
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
`endif
            state          <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (lat_new > max_latency) max_latency <= lat_new;
            state <= ST_ADVANCE;
          end else if (timeout) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
`ifdef ANDTREE_CHK_FIRST_FAIL_EN
            if (!first_fail_vld) begin
              first_fail_idx <= vec_index;
              first_fail_vld <= 1'b1;
            end
`endif
            state <= ST_ADVANCE;
          end else begin
            timer  <= timer + 1'b1;
            streak <= match ? streak + 1'b1 : '0;
          end
        end
        ST_ADVANCE: begin
          timer  <= '0;
          streak <= '0;
          if (&vec_index) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
            state <= ST_DONE;
          end else begin
            vec_index <= vec_index + 1'b1;
            drv       <= N_IN'(gray(32'(vec_index) + 32'd1));
            state     <= ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
